// File: rtl/pdm_demod.sv
// pdm_demod: pulse density demodulator.
// Counts ones in a 1-bit PDM stream over back-to-back windows of
// 2^DUTY_BITS accepted samples and reports the saturated count as a duty
// value with a single-cycle valid pulse. The first window after every
// enable is discarded to let synchroniser and source start-up settle.
module pdm_demod #(
    parameter int DUTY_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sample_en,
    input  logic                 pdm_in,
    output logic [DUTY_BITS-1:0] duty,
    output logic                 valid,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_ACQ   = 2'd2;

    localparam logic [DUTY_BITS-1:0] WIN_LAST = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [DUTY_BITS-1:0]   r_win;
    logic [DUTY_BITS:0]     r_ones;
    logic [DUTY_BITS-1:0]   r_duty;
    logic                   r_valid;

    logic                   w_bit;
    logic                   w_last;
    logic [DUTY_BITS:0]     w_total;
    logic [DUTY_BITS-1:0]   w_sat;
    logic                   w_complete;

    assign w_bit      = r_sync[SYNC_STAGES-1];
    assign w_last     = sample_en && (r_win == WIN_LAST);
    assign w_total    = r_ones + {{DUTY_BITS{1'b0}}, w_bit};
    assign w_complete = (r_state == S_ACQ) && en && w_last;

    // Clamp a full-window count of 2^DUTY_BITS to the largest reportable duty
    always_comb begin
        w_sat = w_total[DUTY_BITS-1:0];
        if (w_total[DUTY_BITS]) begin
            w_sat = '1;
        end
    end

    // Synchronise the asynchronous PDM input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pdm_in};
        end
    end

    // Control FSM with window and ones counters; en low aborts to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_win   <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_win  <= '0;
                    r_ones <= '0;
                    if (en) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_win   <= '0;
                        r_ones  <= '0;
                    end else if (w_last) begin
                        r_state <= S_ACQ;
                        r_win   <= '0;
                        r_ones  <= '0;
                    end else if (sample_en) begin
                        r_win  <= r_win + 1'b1;
                        r_ones <= w_total;
                    end
                end
                S_ACQ: begin
                    if (!en) begin
                        r_state <= S_IDLE;
                        r_win   <= '0;
                        r_ones  <= '0;
                    end else if (w_last) begin
                        r_win  <= '0;
                        r_ones <= '0;
                    end else if (sample_en) begin
                        r_win  <= r_win + 1'b1;
                        r_ones <= w_total;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_win   <= '0;
                    r_ones  <= '0;
                end
            endcase
        end
    end

    // Register the completed window's duty and pulse valid for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_complete;
            if (w_complete) begin
                r_duty <= w_sat;
            end
        end
    end

    assign duty  = r_duty;
    assign valid = r_valid;
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_pdm_demod.sv
// tb_pdm_demod: scoreboard bench for pdm_demod with a first-order PDM
// source model driving the input.
module tb_pdm_demod;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sample_en;
    logic       pdm_in;
    logic [7:0] duty;
    logic       valid;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int cyc       = 0;
    int mode      = 0;   // 0 low, 1 high, 2 generator, 3 random
    int gen_d     = 0;
    int div       = 1;
    int exp_space = 256;
    int ph_gen    = 0;
    int ph_seen   = 0;
    int n_ph      = 0;
    int first_cyc = 0;
    int last_cyc  = 0;
    int t0        = 0;
    int q[$];

    pdm_demod #(.DUTY_BITS(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sample_en (sample_en),
        .pdm_in    (pdm_in),
        .duty      (duty),
        .valid     (valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // PDM source and sample strobe, updated on the falling edge
    initial begin
        int sc;
        int acc;
        int gbit;
        sc = 0;
        acc = 0;
        gbit = 0;
        sample_en = 1'b0;
        pdm_in = 1'b0;
        forever begin
            @(negedge clk);
            sc = (sc + 1) % div;
            sample_en = (sc == 0);
            if (sample_en) begin
                acc  = acc + gen_d;
                gbit = (acc >= 256) ? 1 : 0;
                acc  = acc % 256;
            end
            case (mode)
                0:       pdm_in = 1'b0;
                1:       pdm_in = 1'b1;
                2:       pdm_in = gbit[0];
                default: pdm_in = 1'($urandom % 2);
            endcase
        end
    end

    // Output monitor: pops the scoreboard on every valid pulse
    initial begin
        int prev_v;
        prev_v = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (ph_seen != ph_gen) begin
                    ph_seen = ph_gen;
                    n_ph = 0;
                end
                if (valid) begin
                    chk("valid_double", prev_v, 0);
                    if (q.size() == 0) begin
                        chk("valid_unexpected", int'(valid), 0);
                    end else begin
                        chk("duty", int'(duty), q.pop_front());
                        if (n_ph == 0) first_cyc = cyc;
                        else chk("spacing", cyc - last_cyc, exp_space);
                        last_cyc = cyc;
                        n_ph++;
                    end
                end
                prev_v = int'(valid);
            end else begin
                prev_v = 0;
            end
        end
    end

    task automatic start_phase(input int d_exp, input int n);
        ph_gen++;
        for (int i = 0; i < n; i++) q.push_back(d_exp);
        en = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        int tbl_mode [3];
        int tbl_d    [3];
        int tbl_exp  [3];
        tbl_mode = '{1, 0, 2};
        tbl_d    = '{0, 0, 1};
        tbl_exp  = '{255, 0, 1};

        rst = 1'b0;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_duty", int'(duty), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);

        // Idle with en low and a toggling input
        rst  = 1'b1;
        mode = 3;
        repeat (50) begin
            @(negedge clk);
            #1;
            chk("idle_busy", int'(busy), 0);
        end
        chk("idle_duty", int'(duty), 0);

        // Loopback at duty 0x40
        mode = 2;
        gen_d = 8'h40;
        div = 1;
        exp_space = 256;
        start_phase(8'h40, 4);
        wait_drain(2000);
        chk("lat_loop", first_cyc - t0, 513);

        // Abort at sample 100 of the following window
        repeat (100) @(negedge clk);
        en = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_duty", int'(duty), 8'h40);
        start_phase(8'h40, 1);
        wait_drain(1000);
        chk("lat_abort", first_cyc - t0, 513);
        en = 1'b0;
        repeat (10) @(negedge clk);
        #1;

        // Extremes
        for (int k = 0; k < 3; k++) begin
            mode  = tbl_mode[k];
            gen_d = tbl_d[k];
            repeat (5) @(negedge clk);
            #1;
            start_phase(tbl_exp[k], 1);
            wait_drain(1000);
            en = 1'b0;
            repeat (10) @(negedge clk);
            #1;
        end

        // Strobed sampling every 4th cycle
        mode = 2;
        gen_d = 8'hA5;
        div = 4;
        exp_space = 1024;
        start_phase(8'hA5, 2);
        wait_drain(4000);
        en = 1'b0;
        div = 1;
        exp_space = 256;
        repeat (10) @(negedge clk);
        #1;

        // en dropped on the completing strobe
        gen_d = 8'h40;
        start_phase(8'h40, 1);
        wait_drain(1000);
        gen_d = 8'h80;
        repeat (255) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        #1;
        chk("sim_busy", int'(busy), 0);
        chk("sim_valid", int'(valid), 0);
        chk("sim_duty", int'(duty), 8'h40);
        repeat (300) @(negedge clk);
        #1;
        chk("sim_duty_hold", int'(duty), 8'h40);

        // Asynchronous reset mid-operation
        en = 1'b1;
        repeat (300) @(negedge clk);
        #1;
        chk("run_busy", int'(busy), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_duty", int'(duty), 0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pdm_demod.md
Name: pdm_demod

Overview:
- Pulse density demodulator. Recovers a DUTY_BITS-wide duty value from a 1-bit PDM stream by counting ones over a fixed tumbling window of 2^DUTY_BITS samples.
- Receive-side counterpart of the team's PDM generator. Used for loopback self-test and for decoding external PDM sources such as sensors and comparator outputs.
- Emits one result per window, qualified by a single-cycle valid pulse.

Parameters:
- DUTY_BITS, 8, width of the recovered duty value; window length is 2^DUTY_BITS samples.
- SYNC_STAGES, 2, number of flops in the pdm_in synchroniser chain (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  demodulator enable, level sensitive.
- sample_en  input  1  sample strobe; one PDM bit is consumed per clk cycle in which it is high. Tie high for one sample per clock.
- pdm_in  input  1  PDM bitstream, asynchronous to clk.
- duty  output  DUTY_BITS  last completed window's ones count, saturated.
- valid  output  1  one-cycle pulse when duty updates.
- busy  output  1  high while the state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - Synchroniser flops, window counter and ones counter cleared.
  - State = IDLE; duty = 0, valid = 0, busy = 0.
- Synchroniser: pdm_in passes through SYNC_STAGES flops before use. Input-to-sample latency is SYNC_STAGES clk cycles.
- Counters:
  - Window counter is DUTY_BITS wide and counts sample_en strobes.
  - Ones counter is DUTY_BITS+1 wide so it can hold the full count of 2^DUTY_BITS.
- State machine:
  - IDLE: counters held at 0. When en is high, go to FLUSH on the next cycle.
  - FLUSH: consumes exactly one full window of samples and discards the result; valid stays low. This clears synchroniser and source start-up transients. On the strobe where the window counter equals 2^DUTY_BITS-1, clear both counters and go to ACQ.
  - ACQ: on each strobe, the ones counter adds the synchronised bit and the window counter increments.
- Window completion in ACQ (the strobe with window counter = 2^DUTY_BITS-1):
  - Total = ones counter + current bit.
  - In the next cycle, duty = min(total, 2^DUTY_BITS-1) and valid = 1 for exactly one cycle.
  - In the same cycle the ones counter reloads to 0 and the window counter wraps to 0.
  - State stays ACQ, so windows run back to back with no lost samples.
- en low while in FLUSH or ACQ:
  - Next cycle: state = IDLE and counters cleared; the partial window is discarded.
  - duty holds its last value and no valid pulse is produced.
  - Re-enabling always passes through FLUSH again.
- en low in the same cycle as a completing strobe: en has priority. No valid pulse, duty unchanged.
- sample_en low: counters and state hold; no timeout.
- Saturation: an all-ones window (count 2^DUTY_BITS) reports 2^DUTY_BITS-1; an all-zeros window reports 0.
- Output timing: duty and valid are registered; valid is never high for two consecutive cycles.
- Expected accuracy: for a first-order PDM source with steady duty d, a 2^DUTY_BITS-sample window contains exactly d ones, so duty = d. The exception is d = 2^DUTY_BITS-1 at full scale, which still reports 2^DUTY_BITS-1.

Test Plan:
- Reset and idle: rst low mid-operation -> duty = 0, valid = 0, busy = 0 immediately, without waiting for a clk edge. Release with en low -> outputs stay at reset values and pdm_in toggling has no effect.
- Loopback: PDM generator (DUTY_BITS=8, duty=0x40) drives pdm_in, sample_en = 1, en raised -> no valid during the first 256 samples (FLUSH). First valid arrives 512 samples plus the synchroniser/FSM latency after en. duty = 0x40 on every subsequent valid, with valid pulses spaced exactly 256 cycles apart.
- Extremes: pdm_in held high -> duty = 0xFF. pdm_in held low -> duty = 0x00. Generator duty = 0x01 -> duty = 0x01.
- Strobed sampling: sample_en high every 4th cycle, generator clocked by the same strobe with duty = 0xA5 -> valid spacing 1024 cycles, duty = 0xA5.
- Abort: en dropped at sample 100 of an ACQ window, then re-raised -> no valid pulse, duty holds the previous 0x40. The next valid arrives only after a full FLUSH plus ACQ, with the correct value.
- Simultaneous events: en dropped on the completing strobe -> no valid, duty unchanged, busy low on the next cycle.
